// File: rtl/memmux_scanner.sv
// rtl/memmux_scanner.sv - scan-out address generator, pixel register and frame-boundary buffer swap
module memmux_scanner #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_en,
   output logic [ADDR_WIDTH-1:0] mADDR_V,
   input  logic [DATA_WIDTH-1:0] mDATA_V,
   output logic                  switch,
   input  logic                  swap_req,
   output logic                  swap_ack,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_valid,
   output logic                  frame_start
);

   localparam logic [ADDR_WIDTH-1:0] lastAddr = ADDR_WIDTH'(DEPTH - 1);

   logic [ADDR_WIDTH-1:0] scanAddr;
   logic                  lastPix;
   logic                  swapEvent;

   assign lastPix = (scanAddr == lastAddr);
   // Ack gating keeps a held request from swapping twice on back-to-back frame ends (DEPTH=1).
   assign swapEvent = pix_en && lastPix && swap_req && !swap_ack;
   assign mADDR_V = scanAddr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scanAddr    <= '0;
         switch      <= 1'b0;
         swap_ack    <= 1'b0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         swap_ack <= swapEvent;
         if (swapEvent)
            switch <= ~switch;
         if (pix_en) begin
            pix_data    <= mDATA_V;
            pix_valid   <= 1'b1;
            frame_start <= (scanAddr == '0);
            scanAddr    <= lastPix ? '0 : scanAddr + ADDR_WIDTH'(1);
         end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_memmux_scanner.sv
// tb/tb_memmux_scanner.sv - bench for memmux_scanner: DEPTH=4 and DEPTH=1 builds against a frame-level model
module tb_memmux_scanner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pix_en = 1'b0;
   logic swap_req = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] addr [2];
   logic [7:0] rdat [2];
   logic [7:0] pdat [2];
   logic       sw [2], ack [2], vld [2], fs [2];

   // Behavioural mux plus two RAMs: A[i]=0x10+i, B[i]=0x20+i
   always_comb begin
      for (int k = 0; k < 2; k++)
         rdat[k] = sw[k] ? 8'h20 + addr[k] : 8'h10 + addr[k];
   end

   memmux_scanner #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .pix_en(pix_en), .mADDR_V(addr[0]), .mDATA_V(rdat[0]),
      .switch(sw[0]), .swap_req(swap_req), .swap_ack(ack[0]), .pix_data(pdat[0]),
      .pix_valid(vld[0]), .frame_start(fs[0]));

   memmux_scanner #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .pix_en(pix_en), .mADDR_V(addr[1]), .mDATA_V(rdat[1]),
      .switch(sw[1]), .swap_req(swap_req), .swap_ack(ack[1]), .pix_data(pdat[1]),
      .pix_valid(vld[1]), .frame_start(fs[1]));

   int passCnt = 0;
   int totalCnt = 0;
   bit chkEn = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      totalCnt++;
      if (act == exp) passCnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int ram(input bit s, input int a);
      return s ? 32'h20 + a : 32'h10 + a;
   endfunction

   // Frame-level model: pixels consumed so far, swaps performed, last consumed pixel
   int depthOf [2] = '{4, 1};
   int mCount [2];
   bit mSw [2], mAck [2], mValid [2], mFs [2];
   int mData [2];

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         int pos;
         bit fire;
         if (rst) begin
            mCount[k] = 0; mSw[k] = 0; mAck[k] = 0;
            mData[k] = 0; mValid[k] = 0; mFs[k] = 0;
         end else begin
            pos = mCount[k] % depthOf[k];
            fire = pix_en && (pos == depthOf[k] - 1) && swap_req && !mAck[k];
            if (pix_en) begin
               mData[k] = ram(mSw[k], pos);
               mValid[k] = 1;
               mFs[k] = (pos == 0);
               mCount[k]++;
            end else begin
               mValid[k] = 0;
               mFs[k] = 0;
            end
            if (fire) mSw[k] = ~mSw[k];
            mAck[k] = fire;
         end
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d addr", k), int'(addr[k]), mCount[k] % depthOf[k]);
            check($sformatf("d%0d switch", k), int'(sw[k]), int'(mSw[k]));
            check($sformatf("d%0d swap_ack", k), int'(ack[k]), int'(mAck[k]));
            check($sformatf("d%0d pix_data", k), int'(pdat[k]), mData[k]);
            check($sformatf("d%0d pix_valid", k), int'(vld[k]), int'(mValid[k]));
            check($sformatf("d%0d frame_start", k), int'(fs[k]), int'(mFs[k]));
         end
      end
   end

   task automatic step(input bit en, input bit req);
      pix_en = en;
      swap_req = req;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst addr", int'(addr[0]), 0);
      check("rst switch", int'(sw[0]), 0);
      check("rst valid", int'(vld[0]), 0);
      check("rst ack", int'(ack[0]), 0);
      check("rst pix_data", int'(pdat[0]), 0);
      check("rst frame_start", int'(fs[0]), 0);
      rst = 1'b0;
      chkEn = 1'b1;

      // Continuous scan, no swap: wraps at DEPTH
      step(1, 0);
      check("t1 data", int'(pdat[0]), 'h10);
      check("t1 fs", int'(fs[0]), 1);
      check("t1 addr", int'(addr[0]), 1);
      for (int i = 0; i < 7; i++) step(1, 0);
      check("t1 wrap addr", int'(addr[0]), 0);
      check("t1 last data", int'(pdat[0]), 'h13);
      check("t1 switch", int'(sw[0]), 0);

      // Request raised mid-frame; swap only on the edge consuming addr 3
      step(1, 0);
      step(1, 1);
      step(1, 1);
      check("t2 no mid swap", int'(sw[0]), 0);
      step(1, 1);
      check("t2 switch", int'(sw[0]), 1);
      check("t2 ack", int'(ack[0]), 1);
      step(1, 0);
      check("t2 new buf px0", int'(pdat[0]), 'h20);
      check("t2 ack drop", int'(ack[0]), 0);
      for (int i = 0; i < 3; i++) step(1, 0);
      check("t2 new buf px3", int'(pdat[0]), 'h23);

      // Enable gaps
      step(1, 0);
      check("t3 data", int'(pdat[0]), 'h20);
      step(0, 0);
      check("t3 gap valid", int'(vld[0]), 0);
      check("t3 gap hold", int'(pdat[0]), 'h20);
      check("t3 gap addr", int'(addr[0]), 1);
      step(1, 0);
      check("t3 data2", int'(pdat[0]), 'h21);
      step(0, 0);
      check("t3 addr2", int'(addr[0]), 2);

      // Request held for two frames: one swap per frame end
      step(1, 0);
      step(1, 0);
      for (int i = 0; i < 4; i++) step(1, 1);
      check("t4 swap1", int'(sw[0]), 0);
      for (int i = 0; i < 3; i++) step(1, 1);
      check("t4 no mid swap", int'(sw[0]), 0);
      step(1, 1);
      check("t4 swap2", int'(sw[0]), 1);
      step(1, 0);

      // Mid-frame reset with switch=1 and a request pending
      step(1, 1);
      #2 rst = 1'b1;
      #1;
      check("t5 rst switch", int'(sw[0]), 0);
      check("t5 rst addr", int'(addr[0]), 0);
      check("t5 rst valid", int'(vld[0]), 0);
      check("t5 rst ack", int'(ack[0]), 0);
      swap_req = 1'b0;
      pix_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) step(1, 0);
      check("t5 buf A", int'(pdat[0]), 'h13);
      check("t5 switch", int'(sw[0]), 0);

      // DEPTH=1 build: held request swaps only on alternate cycles
      step(1, 1);
      check("d1 sw a", int'(sw[1]), 1);
      step(1, 1);
      check("d1 sw b", int'(sw[1]), 1);
      check("d1 ack b", int'(ack[1]), 0);
      step(1, 1);
      check("d1 sw c", int'(sw[1]), 0);
      check("d1 ack c", int'(ack[1]), 1);
      step(1, 1);
      check("d1 sw d", int'(sw[1]), 0);
      step(0, 0);
      step(0, 0);

      chkEn = 1'b0;
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
